// File: rtl/ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl
//
// FIFO controller in front of a single-port RAM with a shared bidirectional
// data bus. A three-state FSM (IDLE, WR, RD) performs at most one RAM access
// every two cycles. Each WR or RD state lasts one cycle and then returns to
// IDLE. When a write and a read are both possible in the same IDLE cycle, the
// grant alternates, starting with the write after reset.
//
// Parameters
//   DW        RAM word width
//   AW        RAM address width; FIFO depth is 2**AW
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_valid  producer offers wr_data
//   wr_data   word to store
//   wr_ready  write accepted on an edge where wr_valid && wr_ready
//   rd_req    consumer requests one word
//   rd_ready  read accepted on an edge where rd_req && rd_ready
//   rd_data   last word read; holds until the next read completes
//   rd_valid  one-cycle pulse marking new rd_data
//   full      registered flag, count == 2**AW
//   empty     registered flag, count == 0
//   count     words stored, 0..2**AW
//   mem_we    RAM write strobe (never high together with mem_re)
//   mem_re    RAM read strobe
//   mem_addr  RAM address, 0 outside an access
//   mem_data  RAM data bus; driven only while mem_we=1, otherwise high-Z
//
// Optional feature (macro RAM_FIFO_ERR_EN)
//   ovf       sticky: write offered while full in IDLE
//   unf       sticky: read requested while empty in IDLE
// ----------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
`ifdef RAM_FIFO_ERR_EN
    ,
    output logic          ovf,
    output logic          unf
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);
    localparam logic [AW:0] LAST_CNT = FULL_CNT - 1'b1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    state_t        state;
    op_t           last_op;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] wdata_q;

    logic wr_ok;
    logic rd_ok;
    logic grant_write;

    assign wr_ok       = (state == IDLE) && !full;
    assign rd_ok       = (state == IDLE) && !empty;
    // On a conflict the op opposite to the last one performed wins.
    assign grant_write = (last_op == OP_READ);

    assign wr_ready = wr_ok && !(rd_req && rd_ok && !grant_write);
    assign rd_ready = rd_ok && !(wr_valid && wr_ok && grant_write);

    // mem_we is a reset flop, so the bus releases as soon as rst_n falls.
    assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

    // NOTE: wdata_q is pure datapath qualified by mem_we, so it needs no reset;
    // keeping it out of the reset block avoids a reset-gated enable on it.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_valid && wr_ready) begin
            wdata_q <= wr_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, keeping the FSM order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_op  <= OP_READ;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_valid && wr_ready) begin
                        state    <= WR;
                        mem_we   <= 1'b1;
                        mem_addr <= wr_ptr;
                        last_op  <= OP_WRITE;
                    end else if (rd_req && rd_ready) begin
                        state    <= RD;
                        mem_re   <= 1'b1;
                        mem_addr <= rd_ptr;
                        last_op  <= OP_READ;
                    end
                end
                WR: begin
                    state    <= IDLE;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    wr_ptr   <= wr_ptr + 1'b1;
                    count    <= count + 1'b1;
                    full     <= (count == LAST_CNT);
                    empty    <= 1'b0;
                end
                RD: begin
                    state    <= IDLE;
                    mem_re   <= 1'b0;
                    mem_addr <= '0;
                    rd_data  <= mem_data;
                    rd_valid <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                    count    <= count - 1'b1;
                    full     <= 1'b0;
                    empty    <= (count == (AW+1)'(1));
                end
                default: begin
                    state    <= IDLE;
                    mem_we   <= 1'b0;
                    mem_re   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

`ifdef RAM_FIFO_ERR_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (state == IDLE && wr_valid && full) begin
                ovf <= 1'b1;
            end
            if (state == IDLE && rd_req && empty) begin
                unf <= 1'b1;
            end
        end
    end
`endif

endmodule
